// File: rtl/ekf_step_scheduler.sv
// -----------------------------------------------------------------------------
// ekf_step_scheduler
//
// Purpose:
//   Sequences the charge/discharge EKF estimator pair. One start pulse is issued
//   per sample period. The scheduler then waits for ekf_done and latches SOC and
//   V_RC into stable output registers. A mode change is applied only between
//   iterations, and a one-cycle stop pulse always comes first.
//
// Parameters:
//   PERIOD_CYC   cycles from one start pulse to the next (min 4)
//   TIMEOUT_CYC  max cycles spent in RUN waiting for ekf_done
//   CNT_W        width of the iteration counter and internal cycle counters
//
// Ports:
//   clk          system clock
//   n_rst        synchronous active-low reset
//   enable       1 = schedule iterations, 0 = finish current iteration, then idle
//   mode_req     requested mode (1 = charge, 0 = discharge)
//   ekf_done     estimator done (only its rising edge in RUN counts)
//   ekf_soc      estimator SOC, Q8.16 (integer part [22:16])
//   ekf_vrc      estimator V_RC
//   ekf_start    one-cycle start pulse to the estimator
//   ekf_stop     one-cycle stop pulse (mode switch, timeout, SOC limit)
//   ekf_mode     applied mode, drives the estimator mode select
//   soc_out      last latched SOC
//   vrc_out      last latched V_RC
//   soc_valid    one-cycle pulse when soc_out/vrc_out update
//   busy         1 in START/RUN/LATCH
//   timeout_err  sticky RUN-timeout flag; cleared by reset or enable 1->0
//   soc_limit    (SOC_LIMIT_EN only) sticky SOC-limit flag; cleared like timeout_err
//   iter_cnt     completed iterations; wraps after all-ones
//
// Configuration:
//   SOC_LIMIT_EN  When this macro is defined, the block checks each new SOC
//                 sample. If the sample hits the limit (charge >= 100, or
//                 discharge == 0), the block stops the estimator and enters
//                 HALT. It does not restart until enable toggles.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module ekf_step_scheduler #(
    parameter int unsigned PERIOD_CYC  = 1000,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             enable,
    input  logic             mode_req,
    input  logic             ekf_done,
    input  logic [23:0]      ekf_soc,
    input  logic [23:0]      ekf_vrc,
    output logic             ekf_start,
    output logic             ekf_stop,
    output logic             ekf_mode,
    output logic [23:0]      soc_out,
    output logic [23:0]      vrc_out,
    output logic             soc_valid,
    output logic             busy,
    output logic             timeout_err,
`ifdef SOC_LIMIT_EN
    output logic             soc_limit,
`endif
    output logic [CNT_W-1:0] iter_cnt
);

`ifdef SOC_LIMIT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_SWITCH, S_WAIT, S_START, S_RUN, S_LATCH, S_ERR, S_HALT
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_SWITCH, S_WAIT, S_START, S_RUN, S_LATCH, S_ERR
    } state_t;
`endif

    localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(PERIOD_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYC - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_period_cnt;
    logic [CNT_W-1:0] r_to_cnt;
    logic [CNT_W-1:0] r_iter_cnt;
    logic [23:0]      r_soc;
    logic [23:0]      r_vrc;
    logic             r_mode;
    logic             r_done_d;
    logic             r_en_d;
    logic             r_timeout_err;
`ifdef SOC_LIMIT_EN
    logic             r_soc_limit;
    logic             w_limit;
`endif

    logic [CNT_W-1:0] w_period_next;
    logic [CNT_W-1:0] w_to_next;
    logic             w_period_expired;
    logic             w_to_expired;
    logic             w_done_rise;
    logic             w_en_fall;
    logic             w_mode_diff;
    logic             w_may_start;

    // The period counter saturates at zero. A done that arrives after the
    // period has run out then costs exactly one WAIT cycle.
    assign w_period_next    = (r_period_cnt == '0) ? '0 : r_period_cnt - CNT_W'(1);
    assign w_period_expired = (w_period_next == '0);
    assign w_to_next        = r_to_cnt + CNT_W'(1);
    assign w_to_expired     = (w_to_next == TO_LAST);
    // Edge detection keeps a held-high done from completing a later iteration.
    assign w_done_rise      = ekf_done & ~r_done_d;
    assign w_en_fall        = r_en_d & ~enable;
    assign w_mode_diff      = (mode_req != r_mode);

`ifdef SOC_LIMIT_EN
    // r_soc already holds the new sample while the FSM is in LATCH.
    assign w_limit     = r_mode ? (r_soc[22:16] >= 7'd100) : (r_soc[22:16] == 7'd0);
    assign w_may_start = enable & ~r_soc_limit;
`else
    assign w_may_start = enable;
`endif

    // NOTE: every variable written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_may_start) w_state_next = w_mode_diff ? S_SWITCH : S_START;
            S_SWITCH: w_state_next = S_START;
            S_START:  w_state_next = S_RUN;
            S_RUN: begin
                // Done wins over a timeout that falls in the same cycle.
                if (w_done_rise)       w_state_next = S_LATCH;
                else if (w_to_expired) w_state_next = S_ERR;
            end
            S_LATCH: begin
                w_state_next = enable ? S_WAIT : S_IDLE;
`ifdef SOC_LIMIT_EN
                if (w_limit) w_state_next = S_HALT;
`endif
            end
            S_WAIT: begin
                if (!enable)               w_state_next = S_IDLE;
                else if (w_period_expired) w_state_next = w_mode_diff ? S_SWITCH : S_START;
            end
            default:  w_state_next = S_IDLE;   // S_ERR, S_HALT
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state       <= S_IDLE;
            r_period_cnt  <= '0;
            r_to_cnt      <= '0;
            r_iter_cnt    <= '0;
            r_soc         <= '0;
            r_vrc         <= '0;
            r_mode        <= 1'b0;
            r_done_d      <= 1'b0;
            r_en_d        <= 1'b0;
            r_timeout_err <= 1'b0;
`ifdef SOC_LIMIT_EN
            r_soc_limit   <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_done_d <= ekf_done;
            r_en_d   <= enable;

            if (w_en_fall) begin
                r_timeout_err <= 1'b0;
`ifdef SOC_LIMIT_EN
                r_soc_limit   <= 1'b0;
`endif
            end

            case (r_state)
                S_SWITCH: r_mode <= mode_req;
                S_START: begin
                    r_period_cnt <= PERIOD_LOAD;
                    r_to_cnt     <= '0;
                end
                S_RUN: begin
                    r_period_cnt <= w_period_next;
                    r_to_cnt     <= w_to_next;
                    // Capture on the done edge so the data is already stable in LATCH.
                    if (w_done_rise) begin
                        r_soc      <= ekf_soc;
                        r_vrc      <= ekf_vrc;
                        r_iter_cnt <= r_iter_cnt + CNT_W'(1);
                    end
                end
                S_LATCH: begin
                    r_period_cnt <= w_period_next;
`ifdef SOC_LIMIT_EN
                    if (w_limit) r_soc_limit <= 1'b1;
`endif
                end
                S_WAIT:  r_period_cnt <= w_period_next;
                S_ERR:   r_timeout_err <= 1'b1;
                default: ;
            endcase
        end
    end

    assign ekf_start   = (r_state == S_START);
`ifdef SOC_LIMIT_EN
    assign ekf_stop    = (r_state == S_SWITCH) || (r_state == S_ERR) || (r_state == S_HALT);
    assign soc_limit   = r_soc_limit;
`else
    assign ekf_stop    = (r_state == S_SWITCH) || (r_state == S_ERR);
`endif
    assign ekf_mode    = r_mode;
    assign soc_out     = r_soc;
    assign vrc_out     = r_vrc;
    assign soc_valid   = (r_state == S_LATCH);
    assign busy        = (r_state == S_START) || (r_state == S_RUN) || (r_state == S_LATCH);
    assign timeout_err = r_timeout_err;
    assign iter_cnt    = r_iter_cnt;

endmodule

// File: tb/tb_ekf_step_scheduler.sv
// -----------------------------------------------------------------------------
// tb_ekf_step_scheduler
//
// Two instances share every input:
//   u_a   PERIOD_CYC=20, TIMEOUT_CYC=16
//   u_b   PERIOD_CYC=20, TIMEOUT_CYC=64, used for the late-done scenario
//
// Inputs are driven 1 ns after the rising edge, and outputs are sampled at that
// same point. "Cycle s+k" means k rising edges after the cycle that showed
// ekf_start.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ekf_step_scheduler;
    localparam int unsigned PER  = 20;
    localparam int unsigned TO_A = 16;
    localparam int unsigned TO_B = 64;
    localparam int unsigned CW   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst, enable, mode_req, ekf_done;
    logic [23:0] ekf_soc, ekf_vrc;

    logic          a_start, a_stop, a_mode, a_valid, a_busy, a_terr;
    logic [23:0]   a_soc, a_vrc;
    logic [CW-1:0] a_iter;
    logic          b_start, b_stop, b_mode, b_valid, b_busy, b_terr;
    logic [23:0]   b_soc, b_vrc;
    logic [CW-1:0] b_iter;
`ifdef SOC_LIMIT_EN
    logic          a_lim, b_lim;
`endif

    ekf_step_scheduler #(.PERIOD_CYC(PER), .TIMEOUT_CYC(TO_A), .CNT_W(CW)) u_a (
        .clk(clk), .n_rst(n_rst), .enable(enable), .mode_req(mode_req),
        .ekf_done(ekf_done), .ekf_soc(ekf_soc), .ekf_vrc(ekf_vrc),
        .ekf_start(a_start), .ekf_stop(a_stop), .ekf_mode(a_mode),
        .soc_out(a_soc), .vrc_out(a_vrc), .soc_valid(a_valid), .busy(a_busy),
        .timeout_err(a_terr),
`ifdef SOC_LIMIT_EN
        .soc_limit(a_lim),
`endif
        .iter_cnt(a_iter)
    );

    ekf_step_scheduler #(.PERIOD_CYC(PER), .TIMEOUT_CYC(TO_B), .CNT_W(CW)) u_b (
        .clk(clk), .n_rst(n_rst), .enable(enable), .mode_req(mode_req),
        .ekf_done(ekf_done), .ekf_soc(ekf_soc), .ekf_vrc(ekf_vrc),
        .ekf_start(b_start), .ekf_stop(b_stop), .ekf_mode(b_mode),
        .soc_out(b_soc), .vrc_out(b_vrc), .soc_valid(b_valid), .busy(b_busy),
        .timeout_err(b_terr),
`ifdef SOC_LIMIT_EN
        .soc_limit(b_lim),
`endif
        .iter_cnt(b_iter)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int overlap_cnt = 0;

    // Start and stop must never be high together on either instance.
    always @(negedge clk) begin
        if ((a_start && a_stop) || (b_start && b_stop)) overlap_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Leaves the DUTs in cycle 0: reset state visible, n_rst released.
    task automatic do_reset(input logic en, input logic mreq);
        n_rst = 1'b0; enable = en; mode_req = mreq;
        ekf_done = 1'b0; ekf_soc = '0; ekf_vrc = '0;
        tick_n(2);
        n_rst = 1'b1;
    endtask

    task automatic wait_a_start(input int max_cyc, output bit found, output int waited);
        waited = 0;
        while (!a_start && waited < max_cyc) begin
            tick();
            waited++;
        end
        found = a_start;
    endtask

    task automatic test_reset();
        do_reset(1'b0, 1'b0);
        n_checks++; if (a_start !== 1'b0) $display("FAIL reset_start: got %b want 0", a_start); else n_pass++;
        n_checks++; if (a_stop !== 1'b0) $display("FAIL reset_stop: got %b want 0", a_stop); else n_pass++;
        n_checks++; if (a_mode !== 1'b0) $display("FAIL reset_mode: got %b want 0", a_mode); else n_pass++;
        n_checks++; if (a_soc !== 24'h0) $display("FAIL reset_soc: got %h want 000000", a_soc); else n_pass++;
        n_checks++; if (a_vrc !== 24'h0) $display("FAIL reset_vrc: got %h want 000000", a_vrc); else n_pass++;
        n_checks++; if (a_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", a_valid); else n_pass++;
        n_checks++; if (a_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", a_busy); else n_pass++;
        n_checks++; if (a_terr !== 1'b0) $display("FAIL reset_terr: got %b want 0", a_terr); else n_pass++;
        n_checks++; if (a_iter !== '0) $display("FAIL reset_iter: got %0d want 0", a_iter); else n_pass++;
        tick_n(3);
        n_checks++; if (a_busy !== 1'b0 || a_start !== 1'b0) $display("FAIL idle_disabled: busy=%b start=%b want 0/0", a_busy, a_start); else n_pass++;
    endtask

    // Done 5 cycles after each start; starts exactly PER apart; three iterations.
    task automatic test_periodic();
        logic [23:0] soc_tab [3] = '{24'h123456, 24'h3A8000, 24'h010001};
        logic [23:0] vrc_tab [3] = '{24'h000ABC, 24'hFFF001, 24'h7F0000};
        bit found;
        int waited;
        do_reset(1'b0, 1'b0);
        enable = 1'b1;
        tick();
        n_checks++; if (a_start !== 1'b1) $display("FAIL periodic_first_start: got %b want 1", a_start); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                wait_a_start(40, found, waited);
                n_checks++; if (!found) $display("FAIL periodic_start_seen[%0d]: got 0 want 1", i); else n_pass++;
                n_checks++; if (waited + 7 != int'(PER)) $display("FAIL periodic_gap[%0d]: got %0d want %0d", i, waited + 7, PER); else n_pass++;
            end
            tick_n(5);
            n_checks++; if (a_valid !== 1'b0 || a_busy !== 1'b1) $display("FAIL periodic_run[%0d]: valid=%b busy=%b want 0/1", i, a_valid, a_busy); else n_pass++;
            ekf_done = 1'b1; ekf_soc = soc_tab[i]; ekf_vrc = vrc_tab[i];
            tick();
            ekf_done = 1'b0;
            n_checks++; if (a_valid !== 1'b1) $display("FAIL periodic_valid[%0d]: got %b want 1", i, a_valid); else n_pass++;
            n_checks++; if (a_soc !== soc_tab[i]) $display("FAIL periodic_soc[%0d]: got %h want %h", i, a_soc, soc_tab[i]); else n_pass++;
            n_checks++; if (a_vrc !== vrc_tab[i]) $display("FAIL periodic_vrc[%0d]: got %h want %h", i, a_vrc, vrc_tab[i]); else n_pass++;
            n_checks++; if (a_iter !== CW'(i + 1)) $display("FAIL periodic_iter[%0d]: got %0d want %0d", i, a_iter, i + 1); else n_pass++;
            tick();
            n_checks++; if (a_valid !== 1'b0) $display("FAIL periodic_valid_pulse[%0d]: got %b want 0", i, a_valid); else n_pass++;
        end
    endtask

    // Switch at startup, then a mode_req change mid-RUN is held off until WAIT expiry.
    task automatic test_mode_switch();
        do_reset(1'b1, 1'b1);
        tick();                                   // cycle 1: SWITCH
        n_checks++; if (a_stop !== 1'b1 || a_start !== 1'b0) $display("FAIL switch_stop_c1: stop=%b start=%b want 1/0", a_stop, a_start); else n_pass++;
        n_checks++; if (a_mode !== 1'b0) $display("FAIL switch_mode_c1: got %b want 0", a_mode); else n_pass++;
        tick();                                   // cycle 2: START
        n_checks++; if (a_start !== 1'b1 || a_stop !== 1'b0) $display("FAIL switch_start_c2: start=%b stop=%b want 1/0", a_start, a_stop); else n_pass++;
        n_checks++; if (a_mode !== 1'b1) $display("FAIL switch_mode_c2: got %b want 1", a_mode); else n_pass++;
        tick();                                   // cycle 3: RUN
        mode_req = 1'b0;
        tick_n(4);                                // cycle 7
        ekf_done = 1'b1; ekf_soc = 24'h4B0000; ekf_vrc = 24'h001111;
        tick();                                   // cycle 8: LATCH
        ekf_done = 1'b0;
        n_checks++; if (a_valid !== 1'b1 || a_mode !== 1'b1) $display("FAIL midrun_latch: valid=%b mode=%b want 1/1", a_valid, a_mode); else n_pass++;
        tick_n(13);                               // cycle 21: last WAIT cycle
        n_checks++; if (a_mode !== 1'b1 || a_stop !== 1'b0 || a_start !== 1'b0) $display("FAIL midrun_wait: mode=%b stop=%b start=%b want 1/0/0", a_mode, a_stop, a_start); else n_pass++;
        tick();                                   // cycle 22: SWITCH
        n_checks++; if (a_stop !== 1'b1 || a_start !== 1'b0 || a_mode !== 1'b1) $display("FAIL midrun_switch: stop=%b start=%b mode=%b want 1/0/1", a_stop, a_start, a_mode); else n_pass++;
        tick();                                   // cycle 23: START in new mode
        n_checks++; if (a_start !== 1'b1 || a_stop !== 1'b0 || a_mode !== 1'b0) $display("FAIL midrun_start: start=%b stop=%b mode=%b want 1/0/0", a_start, a_stop, a_mode); else n_pass++;
    endtask

    // No done: stop 16 cycles after start. Then done in the timeout cycle wins.
    task automatic test_timeout();
        do_reset(1'b0, 1'b0);
        enable = 1'b1;
        tick();                                   // s
        n_checks++; if (a_start !== 1'b1) $display("FAIL timeout_start: got %b want 1", a_start); else n_pass++;
        tick_n(15);                               // s+15
        n_checks++; if (a_stop !== 1'b0 || a_busy !== 1'b1) $display("FAIL timeout_early: stop=%b busy=%b want 0/1", a_stop, a_busy); else n_pass++;
        tick();                                   // s+16: ERR
        n_checks++; if (a_stop !== 1'b1 || a_busy !== 1'b0 || a_start !== 1'b0) $display("FAIL timeout_stop: stop=%b busy=%b start=%b want 1/0/0", a_stop, a_busy, a_start); else n_pass++;
        tick();                                   // s+17
        n_checks++; if (a_terr !== 1'b1) $display("FAIL timeout_err_set: got %b want 1", a_terr); else n_pass++;
        n_checks++; if (a_iter !== '0 || a_soc !== 24'h0) $display("FAIL timeout_no_update: iter=%0d soc=%h want 0/000000", a_iter, a_soc); else n_pass++;
        enable = 1'b0;
        tick();                                   // s+18
        n_checks++; if (a_terr !== 1'b0) $display("FAIL timeout_err_clear: got %b want 0", a_terr); else n_pass++;
        enable = 1'b1;
        tick();                                   // s': START
        n_checks++; if (a_start !== 1'b1) $display("FAIL tie_start: got %b want 1", a_start); else n_pass++;
        tick_n(15);                               // s'+15: timeout cycle
        ekf_done = 1'b1; ekf_soc = 24'h0A0000; ekf_vrc = 24'h000042;
        tick();                                   // s'+16
        ekf_done = 1'b0;
        n_checks++; if (a_valid !== 1'b1 || a_stop !== 1'b0) $display("FAIL tie_done_wins: valid=%b stop=%b want 1/0", a_valid, a_stop); else n_pass++;
        n_checks++; if (a_soc !== 24'h0A0000 || a_iter !== CW'(1)) $display("FAIL tie_latch: soc=%h iter=%0d want 0a0000/1", a_soc, a_iter); else n_pass++;
        tick();
        n_checks++; if (a_terr !== 1'b0) $display("FAIL tie_no_err: got %b want 0", a_terr); else n_pass++;
    endtask

    // Done after period expiry (instance b): LATCH, one WAIT, then START. Then reset mid-RUN.
    task automatic test_late_done();
        do_reset(1'b0, 1'b0);
        enable = 1'b1;
        tick();                                   // s
        n_checks++; if (b_start !== 1'b1) $display("FAIL late_start: got %b want 1", b_start); else n_pass++;
        tick_n(30);                               // s+30
        n_checks++; if (b_busy !== 1'b1 || b_stop !== 1'b0) $display("FAIL late_run: busy=%b stop=%b want 1/0", b_busy, b_stop); else n_pass++;
        ekf_done = 1'b1; ekf_soc = 24'h321000; ekf_vrc = 24'h00BEEF;
        tick();                                   // s+31: LATCH
        ekf_done = 1'b0;
        n_checks++; if (b_valid !== 1'b1 || b_iter !== CW'(1) || b_terr !== 1'b0) $display("FAIL late_latch: valid=%b iter=%0d terr=%b want 1/1/0", b_valid, b_iter, b_terr); else n_pass++;
        tick();                                   // s+32: WAIT
        n_checks++; if (b_start !== 1'b0 || b_busy !== 1'b0) $display("FAIL late_wait: start=%b busy=%b want 0/0", b_start, b_busy); else n_pass++;
        tick();                                   // s+33: START
        n_checks++; if (b_start !== 1'b1) $display("FAIL late_next_start: got %b want 1", b_start); else n_pass++;
        tick_n(3);
        n_checks++; if (b_busy !== 1'b1) $display("FAIL rst_pre_busy: got %b want 1", b_busy); else n_pass++;
        n_rst = 1'b0;
        tick();
        n_checks++; if (b_busy !== 1'b0 || b_start !== 1'b0 || b_stop !== 1'b0 || b_valid !== 1'b0) $display("FAIL rst_midrun_ctl: busy=%b start=%b stop=%b valid=%b want 0/0/0/0", b_busy, b_start, b_stop, b_valid); else n_pass++;
        n_checks++; if (b_soc !== 24'h0 || b_vrc !== 24'h0 || b_iter !== '0 || b_mode !== 1'b0) $display("FAIL rst_midrun_data: soc=%h vrc=%h iter=%0d mode=%b want 0", b_soc, b_vrc, b_iter, b_mode); else n_pass++;
`ifdef SOC_LIMIT_EN
        n_checks++; if (b_lim !== 1'b0) $display("FAIL rst_midrun_lim: got %b want 0", b_lim); else n_pass++;
`endif
        n_rst = 1'b1;
    endtask

    // A done held high for several cycles counts as one completion.
    task automatic test_done_held();
        do_reset(1'b0, 1'b0);
        enable = 1'b1;
        tick();                                   // s
        tick_n(3);
        ekf_done = 1'b1; ekf_soc = 24'h222222; ekf_vrc = 24'h000777;
        tick();                                   // s+4: LATCH
        n_checks++; if (a_valid !== 1'b1 || a_iter !== CW'(1)) $display("FAIL held_first: valid=%b iter=%0d want 1/1", a_valid, a_iter); else n_pass++;
        tick_n(2);                                // done still high
        n_checks++; if (a_valid !== 1'b0 || a_iter !== CW'(1)) $display("FAIL held_once: valid=%b iter=%0d want 0/1", a_valid, a_iter); else n_pass++;
        ekf_done = 1'b0;
    endtask

    // enable drops mid-RUN: the iteration completes, then idle with no stop and no restart.
    task automatic test_enable_drop();
        int starts, stops;
        do_reset(1'b0, 1'b0);
        enable = 1'b1;
        tick();                                   // s
        tick_n(2);
        enable = 1'b0;
        tick_n(3);                                // s+5
        ekf_done = 1'b1; ekf_soc = 24'h050000; ekf_vrc = 24'h000005;
        tick();                                   // s+6: LATCH
        ekf_done = 1'b0;
        n_checks++; if (a_valid !== 1'b1 || a_iter !== CW'(1)) $display("FAIL drop_complete: valid=%b iter=%0d want 1/1", a_valid, a_iter); else n_pass++;
        tick();
        n_checks++; if (a_busy !== 1'b0 || a_stop !== 1'b0) $display("FAIL drop_idle: busy=%b stop=%b want 0/0", a_busy, a_stop); else n_pass++;
        starts = 0; stops = 0;
        for (int k = 0; k < 40; k++) begin
            if (a_start) starts++;
            if (a_stop) stops++;
            tick();
        end
        n_checks++; if (starts != 0 || stops != 0) $display("FAIL drop_quiet: starts=%0d stops=%0d want 0/0", starts, stops); else n_pass++;
    endtask

`ifdef SOC_LIMIT_EN
    // Charge mode, SOC 100.0: valid, then stop with soc_limit, no restart until enable toggles.
    task automatic test_soc_limit();
        int starts;
        do_reset(1'b1, 1'b1);
        tick_n(2);                                // cycle 2: START, charge
        n_checks++; if (a_start !== 1'b1 || a_mode !== 1'b1) $display("FAIL lim_start: start=%b mode=%b want 1/1", a_start, a_mode); else n_pass++;
        tick_n(5);
        ekf_done = 1'b1; ekf_soc = 24'h640000; ekf_vrc = 24'h000100;
        tick();                                   // LATCH
        ekf_done = 1'b0;
        n_checks++; if (a_valid !== 1'b1 || a_lim !== 1'b0) $display("FAIL lim_latch: valid=%b lim=%b want 1/0", a_valid, a_lim); else n_pass++;
        tick();                                   // HALT
        n_checks++; if (a_stop !== 1'b1 || a_lim !== 1'b1) $display("FAIL lim_halt: stop=%b lim=%b want 1/1", a_stop, a_lim); else n_pass++;
        starts = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (a_start) starts++;
        end
        n_checks++; if (starts != 0 || a_lim !== 1'b1) $display("FAIL lim_hold: starts=%0d lim=%b want 0/1", starts, a_lim); else n_pass++;
        enable = 1'b0;
        tick();
        n_checks++; if (a_lim !== 1'b0) $display("FAIL lim_clear: got %b want 0", a_lim); else n_pass++;
        enable = 1'b1;
        tick();
        n_checks++; if (a_start !== 1'b1) $display("FAIL lim_restart: got %b want 1", a_start); else n_pass++;
    endtask
`endif

    initial begin
        n_rst = 1'b0; enable = 1'b0; mode_req = 1'b0;
        ekf_done = 1'b0; ekf_soc = '0; ekf_vrc = '0;
        test_reset();
        test_periodic();
        test_mode_switch();
        test_timeout();
        test_late_done();
        test_done_held();
        test_enable_drop();
`ifdef SOC_LIMIT_EN
        test_soc_limit();
`endif
        n_checks++; if (overlap_cnt != 0) $display("FAIL start_stop_overlap: got %0d want 0", overlap_cnt); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
